// File: rtl/rvga_mem_arbiter.sv
// rvga_mem_arbiter: merges imem (read-only) and dmem (read/write) onto one shared single-port memory, one transaction outstanding.
// Latency: request seen in IDLE in cycle N -> mem_v_o in N+1; response pulse one cycle after mem_rvalid_i.
// Backpressure: mem_ready_i=0 holds mem_v_o/addr/we/wdata stable; each core channel holds its request until its own resp pulse.
//
// Ports:
//   clk_i, rst_i (async, active-low)
//   imem_v_i/imem_addr_i -> imem_data_o/imem_resp_v_o                      fetch channel
//   dmem_r_v_i/dmem_w_v_i/dmem_addr_i/dmem_data_i -> dmem_data_o/dmem_resp_v_o  data channel
//   mem_v_o/mem_we_o/mem_addr_o/mem_wdata_o, mem_ready_i, mem_rdata_i/mem_rvalid_i  shared memory
module rvga_mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              imem_v_i,
    input  logic [ADDR_W-1:0] imem_addr_i,
    output logic [DATA_W-1:0] imem_data_o,
    output logic              imem_resp_v_o,
    input  logic              dmem_r_v_i,
    input  logic              dmem_w_v_i,
    input  logic [ADDR_W-1:0] dmem_addr_i,
    input  logic [DATA_W-1:0] dmem_data_i,
    output logic [DATA_W-1:0] dmem_data_o,
    output logic              dmem_resp_v_o,
    output logic              mem_v_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic              mem_ready_i,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_rvalid_i
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;
    typedef enum logic {CH_I, CH_D} chan_t;

    state_t            state_q, state_d;
    chan_t             owner_q, last_grant_q, grant_ch;
    logic              grant, done;
    logic              pend_i, pend_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] idata_q, ddata_q;
    logic              iresp_q, dresp_q;

    assign pend_i = imem_v_i;
    // A simultaneous read+write strobe is treated as a write (we follows dmem_w_v_i).
    assign pend_d = dmem_r_v_i | dmem_w_v_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        grant    = 1'b0;
        grant_ch = CH_I;
        done     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // While a response pulse is on the outputs the core has not yet had a
                // chance to retire its request, so hold off granting for that cycle.
                if (!iresp_q && !dresp_q && (pend_i || pend_d)) begin
                    grant = 1'b1;
                    if (pend_i && pend_d) grant_ch = (last_grant_q == CH_I) ? CH_D : CH_I;
                    else                  grant_ch = pend_i ? CH_I : CH_D;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready_i) begin
                    // Zero-wait memory answers in the acceptance cycle itself.
                    if (mem_rvalid_i) begin
                        done    = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid_i) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_q      <= CH_I;
            last_grant_q <= CH_D;
            addr_q       <= '0;
            we_q         <= 1'b0;
            wdata_q      <= '0;
            idata_q      <= '0;
            ddata_q      <= '0;
            iresp_q      <= 1'b0;
            dresp_q      <= 1'b0;
        end else begin
            iresp_q <= done && (owner_q == CH_I);
            dresp_q <= done && (owner_q == CH_D);
            if (grant) begin
                owner_q      <= grant_ch;
                last_grant_q <= grant_ch;
                if (grant_ch == CH_D) begin
                    addr_q  <= dmem_addr_i;
                    we_q    <= dmem_w_v_i;
                    wdata_q <= dmem_data_i;
                end else begin
                    addr_q  <= imem_addr_i;
                    we_q    <= 1'b0;
                    wdata_q <= '0;
                end
            end
            if (done && (owner_q == CH_I))          idata_q <= mem_rdata_i;
            // Write acks carry no data; keep the last read word visible.
            if (done && (owner_q == CH_D) && !we_q) ddata_q <= mem_rdata_i;
        end
    end

    assign mem_v_o       = (state_q == ST_REQ);
    assign mem_we_o      = we_q;
    assign mem_addr_o    = addr_q;
    assign mem_wdata_o   = wdata_q;
    assign imem_data_o   = idata_q;
    assign dmem_data_o   = ddata_q;
    assign imem_resp_v_o = iresp_q;
    assign dmem_resp_v_o = dresp_q;

endmodule

// File: tb/tb_rvga_mem_arbiter.sv
// tb_rvga_mem_arbiter: directed bench for rvga_mem_arbiter with a transaction-level reference model.
// Latency: n/a (bench).
// Backpressure: bench memory responder applies a configurable ready delay and response latency.
module tb_rvga_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        imem_v_i;
    logic [31:0] imem_addr_i;
    logic [31:0] imem_data_o;
    logic        imem_resp_v_o;
    logic        dmem_r_v_i, dmem_w_v_i;
    logic [31:0] dmem_addr_i, dmem_data_i, dmem_data_o;
    logic        dmem_resp_v_o;
    logic        mem_v_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic        mem_ready_i;
    logic [31:0] mem_rdata_i;
    logic        mem_rvalid_i;

    rvga_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .imem_v_i(imem_v_i), .imem_addr_i(imem_addr_i),
        .imem_data_o(imem_data_o), .imem_resp_v_o(imem_resp_v_o),
        .dmem_r_v_i(dmem_r_v_i), .dmem_w_v_i(dmem_w_v_i),
        .dmem_addr_i(dmem_addr_i), .dmem_data_i(dmem_data_i),
        .dmem_data_o(dmem_data_o), .dmem_resp_v_o(dmem_resp_v_o),
        .mem_v_o(mem_v_o), .mem_we_o(mem_we_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_ready_i(mem_ready_i), .mem_rdata_i(mem_rdata_i),
        .mem_rvalid_i(mem_rvalid_i)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem_img [logic [31:0]];
    int          r_ready_delay = 0;
    int          r_lat         = 1;
    logic        r_stray       = 1'b0;
    logic        r_busy        = 1'b0;
    int          r_cnt         = 0;
    int          r_hold        = 0;
    logic [31:0] r_data        = '0;

    function automatic logic [31:0] rd_word(input logic [31:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return ~a;
    endfunction

    initial begin
        mem_ready_i  = 1'b0;
        mem_rvalid_i = 1'b0;
        mem_rdata_i  = '0;
        forever begin
            @(posedge clk_i); #1;
            mem_ready_i  = 1'b0;
            mem_rvalid_i = 1'b0;
            mem_rdata_i  = '0;
            if (!rst_i) begin
                r_busy = 1'b0;
                r_hold = 0;
            end else if (r_stray) begin
                mem_rvalid_i = 1'b1;
                mem_rdata_i  = 32'h5757_5757;
            end else if (r_busy) begin
                r_cnt--;
                if (r_cnt == 0) begin
                    mem_rvalid_i = 1'b1;
                    mem_rdata_i  = r_data;
                    r_busy       = 1'b0;
                end
            end else if (mem_v_o) begin
                if (r_hold == r_ready_delay) begin
                    mem_ready_i = 1'b1;
                    r_hold      = 0;
                    if (mem_we_o) begin
                        mem_img[mem_addr_o] = mem_wdata_o;
                        r_data = 32'hBAD0_BAD0;
                    end else begin
                        r_data = rd_word(mem_addr_o);
                    end
                    if (r_lat == 0) begin
                        mem_rvalid_i = 1'b1;
                        mem_rdata_i  = r_data;
                    end else begin
                        r_busy = 1'b1;
                        r_cnt  = r_lat;
                    end
                end else begin
                    r_hold++;
                end
            end
        end
    end

    // ---------------- reference model + per-cycle compare ----------------
    // Transaction view: a granted request is "open" until its response; it is on the
    // memory bus until accepted; the response shows up as a pulse the cycle after rvalid.
    logic        m_open, m_acc, m_pulse, m_pchan, m_last, m_chan, m_we, pulse_now;
    logic [31:0] m_addr, m_wdata, m_ihold, m_dhold;
    logic        pi, pd;

    int          n_ipulse = 0, n_dpulse = 0, n_memv = 0, n_acc = 0;
    logic [31:0] acc_addr_q [$];
    logic        acc_we_q   [$];
    logic [31:0] acc_wdat_q [$];
    logic        pulse_ch_q [$];
    int          pulse_cy_q [$];
    logic [31:0] last_ipulse_data = '0;

    always @(negedge clk_i) begin
        cyc++;
        if (!rst_i) begin
            m_open = 0; m_acc = 0; m_pulse = 0; m_pchan = 0; m_last = 1'b1;
            m_chan = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_ihold = '0; m_dhold = '0;
            chk("rst_mem_addr", mem_addr_o, 32'h0);
            chk("rst_mem_we", {31'b0, mem_we_o}, 32'h0);
            chk("rst_mem_wdata", mem_wdata_o, 32'h0);
        end
        chk("mem_v", {31'b0, mem_v_o}, {31'b0, m_open && !m_acc});
        if (m_open && !m_acc) begin
            chk("mem_addr", mem_addr_o, m_addr);
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, m_we});
            if (m_we) chk("mem_wdata", mem_wdata_o, m_wdata);
        end
        chk("imem_resp_v", {31'b0, imem_resp_v_o}, {31'b0, m_pulse && !m_pchan});
        chk("dmem_resp_v", {31'b0, dmem_resp_v_o}, {31'b0, m_pulse && m_pchan});
        chk("imem_data", imem_data_o, m_ihold);
        chk("dmem_data", dmem_data_o, m_dhold);

        // observation counters for the directed checks
        if (mem_v_o) n_memv++;
        if (mem_v_o && mem_ready_i && rst_i) begin
            n_acc++;
            acc_addr_q.push_back(mem_addr_o);
            acc_we_q.push_back(mem_we_o);
            acc_wdat_q.push_back(mem_wdata_o);
        end
        if (imem_resp_v_o) begin
            n_ipulse++; last_ipulse_data = imem_data_o;
            pulse_ch_q.push_back(1'b0); pulse_cy_q.push_back(cyc);
        end
        if (dmem_resp_v_o) begin
            n_dpulse++;
            pulse_ch_q.push_back(1'b1); pulse_cy_q.push_back(cyc);
        end

        if (rst_i) begin
            pulse_now = m_pulse;
            m_pulse   = 1'b0;
            if (m_open) begin
                if (!m_acc && mem_ready_i) m_acc = 1'b1;
                if (m_acc && mem_rvalid_i) begin
                    m_pulse = 1'b1;
                    m_pchan = m_chan;
                    if (!m_we) begin
                        if (m_chan) m_dhold = mem_rdata_i;
                        else        m_ihold = mem_rdata_i;
                    end
                    m_open = 1'b0;
                    m_acc  = 1'b0;
                end
            end else if (!pulse_now) begin
                pi = imem_v_i;
                pd = dmem_r_v_i | dmem_w_v_i;
                if (pi || pd) begin
                    m_chan = (pi && pd) ? !m_last : pd;
                    m_last = m_chan;
                    m_open = 1'b1;
                    m_acc  = 1'b0;
                    if (m_chan) begin
                        m_addr = dmem_addr_i; m_we = dmem_w_v_i; m_wdata = dmem_data_i;
                    end else begin
                        m_addr = imem_addr_i; m_we = 1'b0; m_wdata = '0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk_i); #1;
    endtask

    // Waits for any response pulse; returns positioned #1 after the next rising edge.
    task automatic wait_resp(input int budget);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk_i);
            if (imem_resp_v_o || dmem_resp_v_o) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL resp_timeout: no response pulse within %0d cycles (cycle %0d)", budget, cyc);
        end
        step();
    endtask

    task automatic do_reset(input int n);
        rst_i = 1'b0;
        imem_v_i = 0; dmem_r_v_i = 0; dmem_w_v_i = 0;
        repeat (n) step();
        rst_i = 1'b1;
    endtask

    int i0, d0, v0, a0, p0;

    initial begin
        rst_i = 1'b1;
        imem_v_i = 0; imem_addr_i = '0;
        dmem_r_v_i = 0; dmem_w_v_i = 0; dmem_addr_i = '0; dmem_data_i = '0;
        mem_img[32'h0000_0100] = 32'h0010_0093;
        #2;
        do_reset(3);

        // Reset: nothing requested, bus stays quiet.
        repeat (10) step();
        chk("reset_no_memv", n_memv, 0);
        chk("reset_no_pulse", n_ipulse + n_dpulse, 0);

        // Single fetch: ready at once, rvalid two cycles after acceptance.
        r_ready_delay = 0; r_lat = 2;
        i0 = n_ipulse; d0 = n_dpulse; v0 = n_memv;
        imem_v_i = 1; imem_addr_i = 32'h0000_0100;
        wait_resp(40);
        imem_v_i = 0;
        repeat (4) step();
        chk("fetch_ipulses", n_ipulse - i0, 1);
        chk("fetch_dpulses", n_dpulse - d0, 0);
        chk("fetch_memv_cycles", n_memv - v0, 1);
        chk("fetch_data", last_ipulse_data, 32'h0010_0093);
        chk("fetch_addr", acc_addr_q[acc_addr_q.size()-1], 32'h0000_0100);

        // Dmem read then write to the same word; write ack must not touch dmem_data_o.
        r_lat = 1;
        dmem_r_v_i = 1; dmem_addr_i = 32'h8000_0004;
        wait_resp(40);
        dmem_r_v_i = 0;
        step();
        chk("dread_data", dmem_data_o, 32'h7FFF_FFFB);
        d0 = n_dpulse;
        dmem_w_v_i = 1; dmem_addr_i = 32'h8000_0004; dmem_data_i = 32'hDEAD_BEEF;
        wait_resp(40);
        dmem_w_v_i = 0;
        repeat (2) step();
        chk("dwrite_pulses", n_dpulse - d0, 1);
        chk("dwrite_we", {31'b0, acc_we_q[acc_we_q.size()-1]}, 32'h1);
        chk("dwrite_wdata", acc_wdat_q[acc_wdat_q.size()-1], 32'hDEAD_BEEF);
        chk("dwrite_data_kept", dmem_data_o, 32'h7FFF_FFFB);
        dmem_r_v_i = 1;
        wait_resp(40);
        dmem_r_v_i = 0;
        step();
        chk("dreadback", dmem_data_o, 32'hDEAD_BEEF);

        // Simultaneous requests right after reset, zero-wait memory: I, D, I, D every 3 cycles.
        do_reset(2);
        step();
        r_ready_delay = 0; r_lat = 0;
        a0 = acc_addr_q.size(); p0 = pulse_ch_q.size();
        imem_v_i = 1; imem_addr_i = 32'h0000_0200;
        dmem_r_v_i = 1; dmem_addr_i = 32'h8000_0010;
        for (int k = 0; k < 4; k++) wait_resp(40);
        imem_v_i = 0; dmem_r_v_i = 0;
        repeat (4) step();
        chk("alt_n_acc", acc_addr_q.size() - a0, 4);
        chk("alt_g0", acc_addr_q[a0],   32'h0000_0200);
        chk("alt_g1", acc_addr_q[a0+1], 32'h8000_0010);
        chk("alt_g2", acc_addr_q[a0+2], 32'h0000_0200);
        chk("alt_g3", acc_addr_q[a0+3], 32'h8000_0010);
        chk("alt_p0", {31'b0, pulse_ch_q[p0]},   32'h0);
        chk("alt_p3", {31'b0, pulse_ch_q[p0+3]}, 32'h1);
        chk("alt_period", pulse_cy_q[p0+1] - pulse_cy_q[p0], 3);
        chk("alt_period2", pulse_cy_q[p0+3] - pulse_cy_q[p0+2], 3);

        // Backpressure: 5 cycles of ready=0; read+write strobes together act as a write.
        r_ready_delay = 5; r_lat = 1;
        v0 = n_memv; a0 = n_acc;
        dmem_r_v_i = 1; dmem_w_v_i = 1; dmem_addr_i = 32'h8000_0020; dmem_data_i = 32'h1234_5678;
        wait_resp(40);
        dmem_r_v_i = 0; dmem_w_v_i = 0;
        repeat (3) step();
        chk("bp_memv_cycles", n_memv - v0, 6);
        chk("bp_one_accept", n_acc - a0, 1);
        chk("bp_we", {31'b0, acc_we_q[acc_we_q.size()-1]}, 32'h1);

        // Reset during WAIT, then a stray rvalid in IDLE: no pulses, bus stays idle.
        r_ready_delay = 0; r_lat = 20;
        imem_v_i = 1; imem_addr_i = 32'h0000_0300;
        repeat (4) step();
        i0 = n_ipulse; d0 = n_dpulse;
        do_reset(2);
        v0 = n_memv;
        r_stray = 1'b1;
        repeat (3) step();
        r_stray = 1'b0;
        repeat (6) step();
        chk("rstw_no_ipulse", n_ipulse - i0, 0);
        chk("rstw_no_dpulse", n_dpulse - d0, 0);
        chk("rstw_no_memv", n_memv - v0, 0);
        chk("rstw_idata", imem_data_o, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
